// File: rtl/servo_ramp.sv
// Servo setpoint stage: accepts clamped target pulse widths and slews the commanded
// width toward the target by a programmable step once per PWM frame.
module servo_ramp #(
    parameter logic [31:0] PERIOD = 32'd2_000_000,
    parameter logic [31:0] D_MIN  = 32'd100_000,
    parameter logic [31:0] D_MAX  = 32'd200_000,
    parameter logic [31:0] D_INIT = 32'd150_000
) (
    input  logic        clk,
    input  logic        res,
    input  logic        en,
    input  logic [31:0] tgt,
    input  logic        tgt_valid,
    output logic        tgt_ready,
    input  logic [31:0] step,
    output logic [31:0] d,
    output logic [31:0] t,
    output logic        pwm_en,
    output logic        frame_tick,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RAMP = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_cnt;
    logic [31:0] r_d;
    logic [31:0] r_tgt;
    logic        r_tick;
    logic        r_done;
    logic        r_pwm_en;
    logic [31:0] w_d_nxt;
    logic [31:0] w_tgt_nxt;
    logic        w_done_nxt;
    logic        w_xfer;
    logic        w_step_now;
    logic [31:0] w_clamped;
    logic [31:0] w_diff;

    assign w_xfer     = tgt_valid && (r_state == S_IDLE);
    // A disabled run freezes the ramp even if a tick is still showing.
    assign w_step_now = (r_state == S_RAMP) && r_tick && en;
    assign w_clamped  = (tgt < D_MIN) ? D_MIN : ((tgt > D_MAX) ? D_MAX : tgt);
    assign w_diff     = (r_tgt >= r_d) ? (r_tgt - r_d) : (r_d - r_tgt);

    always_ff @(posedge clk) begin
        if (!res) begin
            r_cnt    <= '0;
            r_tick   <= 1'b0;
            r_pwm_en <= 1'b0;
        end else begin
            r_pwm_en <= en;
            if (en) begin
                r_tick <= (r_cnt == PERIOD - 32'd1);
                r_cnt  <= (r_cnt == PERIOD - 32'd1) ? '0 : r_cnt + 32'd1;
            end else begin
                r_tick <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            r_state <= S_IDLE;
            r_d     <= D_INIT;
            r_tgt   <= D_INIT;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_d     <= w_d_nxt;
            r_tgt   <= w_tgt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_state_nxt = r_state;
        w_d_nxt     = r_d;
        w_tgt_nxt   = r_tgt;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_tgt_nxt   = w_clamped;
                    w_state_nxt = S_RAMP;
                end
            end
            S_RAMP: begin
                if (w_step_now) begin
                    if ((step == 32'd0) || (w_diff <= step)) begin
                        w_d_nxt     = r_tgt;
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (r_tgt > r_d) begin
                        w_d_nxt = r_d + step;
                    end else begin
                        w_d_nxt = r_d - step;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign tgt_ready  = (r_state == S_IDLE);
    assign busy       = (r_state == S_RAMP);
    assign d          = r_d;
    assign t          = PERIOD;
    assign pwm_en     = r_pwm_en;
    assign frame_tick = r_tick;
    assign done       = r_done;

endmodule
